// File: rtl/tcm_rom_arb_if.sv
// Bus bundle between the two ROM requesters, the shared ROM read port and
// the tcm_rom_arb arbiter. The arbiter takes the slave side.
interface tcm_rom_arb_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
);
  // Port 0: instruction fetch path
  logic              req0_rd_i;
  logic [ADDR_W-1:0] req0_addr_i;
  logic [1:0]        req0_len_i;
  logic              req0_accept_o;
  logic              req0_valid_o;
  logic              req0_last_o;
  logic [DATA_W-1:0] req0_data_o;

  // Port 1: data / debug read path
  logic              req1_rd_i;
  logic [ADDR_W-1:0] req1_addr_i;
  logic [1:0]        req1_len_i;
  logic              req1_accept_o;
  logic              req1_valid_o;
  logic              req1_last_o;
  logic [DATA_W-1:0] req1_data_o;

  // ROM read port; the ROM registers the address internally
  logic [ADDR_W-1:0] rom_addr_o;
  logic [DATA_W-1:0] rom_data_i;

  modport slave (
    input  req0_rd_i, req0_addr_i, req0_len_i,
    output req0_accept_o, req0_valid_o, req0_last_o, req0_data_o,
    input  req1_rd_i, req1_addr_i, req1_len_i,
    output req1_accept_o, req1_valid_o, req1_last_o, req1_data_o,
    output rom_addr_o,
    input  rom_data_i
  );

  modport master (
    output req0_rd_i, req0_addr_i, req0_len_i,
    input  req0_accept_o, req0_valid_o, req0_last_o, req0_data_o,
    output req1_rd_i, req1_addr_i, req1_len_i,
    input  req1_accept_o, req1_valid_o, req1_last_o, req1_data_o,
    input  rom_addr_o,
    output rom_data_i
  );
endinterface

// File: rtl/tcm_rom_arb.sv
// Round-robin arbiter and burst sequencer sharing one single-cycle-latency
// ROM read port between two requesters; responses return one cycle later.
module tcm_rom_arb #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 64
) (
  input  logic         clk_i,
  input  logic         rst_i,
  tcm_rom_arb_if.slave bus
);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              last_q, last_d;       // port granted most recently
  logic              owner_q, owner_d;     // owner of the running burst
  logic [1:0]        rem_q, rem_d;         // beats still to issue after this one
  logic [ADDR_W-1:0] baddr_q, baddr_d;

  logic              rvalid_q, rowner_q, rlast_q;

  logic              grant0, grant1;
  logic              issue, beat_owner, beat_last;
  logic              accept0, accept1;
  logic [ADDR_W-1:0] rom_addr;

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    owner_d    = owner_q;
    rem_d      = rem_q;
    baddr_d    = baddr_q;
    accept0    = 1'b0;
    accept1    = 1'b0;
    rom_addr   = bus.req0_addr_i;
    issue      = 1'b0;
    beat_owner = 1'b0;
    beat_last  = 1'b0;
    grant0     = 1'b0;
    grant1     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // On a tie, the port that lost the previous arbitration wins.
        grant0 = bus.req0_rd_i & (~bus.req1_rd_i | last_q);
        grant1 = bus.req1_rd_i & (~bus.req0_rd_i | ~last_q);

        if (grant0) begin
          accept0    = 1'b1;
          rom_addr   = bus.req0_addr_i;
          issue      = 1'b1;
          beat_owner = 1'b0;
          beat_last  = (bus.req0_len_i == 2'd0);
          last_d     = 1'b0;
          if (bus.req0_len_i != 2'd0) begin
            owner_d = 1'b0;
            baddr_d = bus.req0_addr_i + 1'b1;
            rem_d   = bus.req0_len_i;
            state_d = S_BURST;
          end
        end else if (grant1) begin
          accept1    = 1'b1;
          rom_addr   = bus.req1_addr_i;
          issue      = 1'b1;
          beat_owner = 1'b1;
          beat_last  = (bus.req1_len_i == 2'd0);
          last_d     = 1'b1;
          if (bus.req1_len_i != 2'd0) begin
            owner_d = 1'b1;
            baddr_d = bus.req1_addr_i + 1'b1;
            rem_d   = bus.req1_len_i;
            state_d = S_BURST;
          end
        end
      end

      S_BURST: begin
        // Address wraps modulo 2^ADDR_W through natural overflow.
        rom_addr   = baddr_q;
        issue      = 1'b1;
        beat_owner = owner_q;
        beat_last  = (rem_q == 2'd1);
        baddr_d    = baddr_q + 1'b1;
        rem_d      = rem_q - 2'd1;
        if (rem_q == 2'd1) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
      rem_q    <= 2'd0;
      baddr_q  <= '0;
      rvalid_q <= 1'b0;
      rowner_q <= 1'b0;
      rlast_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      rem_q    <= rem_d;
      baddr_q  <= baddr_d;
      rvalid_q <= issue;
      rowner_q <= beat_owner;
      rlast_q  <= beat_last;
    end
  end

  assign bus.rom_addr_o    = rom_addr;
  assign bus.req0_accept_o = accept0;
  assign bus.req1_accept_o = accept1;

  // The ROM data bus is shared; each port qualifies it with its own valid.
  assign bus.req0_valid_o  = rvalid_q & ~rowner_q;
  assign bus.req1_valid_o  = rvalid_q & rowner_q;
  assign bus.req0_last_o   = bus.req0_valid_o & rlast_q;
  assign bus.req1_last_o   = bus.req1_valid_o & rlast_q;
  assign bus.req0_data_o   = bus.rom_data_i;
  assign bus.req1_data_o   = bus.rom_data_i;

endmodule

// File: tb/tb_tcm_rom_arb.sv
// Scoreboard bench for tcm_rom_arb: directed request vectors push expected
// beats; a negedge monitor pops and compares every returned beat.
module tb_tcm_rom_arb;

  localparam int ADDR_W = 14;
  localparam int DATA_W = 64;

  typedef struct {
    logic              port;
    logic [ADDR_W-1:0] addr;
    logic              last;
  } beat_t;

  logic  clk_i = 1'b0;
  logic  rst_i = 1'b1;
  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  tcm_rom_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  tcm_rom_arb #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk_i = ~clk_i;

  // Distinct, address-derived contents so a wrong address is visible in data.
  function automatic logic [DATA_W-1:0] rom_fn(input logic [ADDR_W-1:0] a);
    return {16'hC0DE, {2'b00, a}, 16'h5A5A, ~{2'b00, a}};
  endfunction

  // Single-cycle-latency ROM model
  always @(posedge clk_i) bus.rom_data_i <= rom_fn(bus.rom_addr_o);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response beat must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (bus.req0_valid_o === 1'b1 || bus.req1_valid_o === 1'b1) begin
      beat_t e;
      if (exp_q.size() == 0) begin
        check("unexpected_beat", {62'd0, bus.req1_valid_o, bus.req0_valid_o}, 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("beat_both_valid", {63'd0, bus.req0_valid_o & bus.req1_valid_o}, 64'd0);
        check("beat_port", {63'd0, bus.req1_valid_o}, {63'd0, e.port});
        if (e.port) begin
          check("beat_last1", {63'd0, bus.req1_last_o}, {63'd0, e.last});
          check("beat_data1", bus.req1_data_o, rom_fn(e.addr));
        end else begin
          check("beat_last0", {63'd0, bus.req0_last_o}, {63'd0, e.last});
          check("beat_data0", bus.req0_data_o, rom_fn(e.addr));
        end
      end
    end
  end

  // Check the combinational outputs for this cycle, queue the beat it
  // should issue, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic ea0, input logic ea1,
                      input logic [ADDR_W-1:0] eaddr, input logic iss,
                      input logic port, input logic lst);
    beat_t b;
    @(negedge clk_i);
    check({tag, "_accept0"}, {63'd0, bus.req0_accept_o}, {63'd0, ea0});
    check({tag, "_accept1"}, {63'd0, bus.req1_accept_o}, {63'd0, ea1});
    check({tag, "_rom_addr"}, {50'd0, bus.rom_addr_o}, {50'd0, eaddr});
    if (iss) begin
      b.port = port;
      b.addr = eaddr;
      b.last = lst;
      exp_q.push_back(b);
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    bus.req0_rd_i   = 1'b0;
    bus.req0_addr_i = 14'h0055;
    bus.req0_len_i  = 2'd0;
    bus.req1_rd_i   = 1'b0;
    bus.req1_addr_i = 14'h0000;
    bus.req1_len_i  = 2'd0;

    // Reset state
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_valid0", {63'd0, bus.req0_valid_o}, 64'd0);
    check("rst_valid1", {63'd0, bus.req1_valid_o}, 64'd0);
    check("rst_last0", {63'd0, bus.req0_last_o}, 64'd0);
    check("rst_accept0", {63'd0, bus.req0_accept_o}, 64'd0);
    check("rst_rom_addr", {50'd0, bus.rom_addr_o}, 64'h0055);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Single read on port 0
    bus.req0_rd_i = 1'b1; bus.req0_addr_i = 14'h0010; bus.req0_len_i = 2'd0;
    step("single0", 1, 0, 14'h0010, 1, 0, 1);
    bus.req0_rd_i = 1'b0;

    // Single read on port 1, leaves port 1 as most recent grant
    bus.req1_rd_i = 1'b1; bus.req1_addr_i = 14'h0005; bus.req1_len_i = 2'd0;
    step("single1", 0, 1, 14'h0005, 1, 1, 1);

    // Both hold single reads: grants alternate 0,1,0,1 with no bubble
    bus.req0_rd_i = 1'b1; bus.req0_addr_i = 14'h0100;
    bus.req1_addr_i = 14'h0200;
    step("rr_a", 1, 0, 14'h0100, 1, 0, 1);
    step("rr_b", 0, 1, 14'h0200, 1, 1, 1);
    step("rr_c", 1, 0, 14'h0100, 1, 0, 1);
    step("rr_d", 0, 1, 14'h0200, 1, 1, 1);
    bus.req1_rd_i = 1'b0;

    // Port 0 alone so port 1 wins the next tie
    bus.req0_addr_i = 14'h0040;
    step("single0b", 1, 0, 14'h0040, 1, 0, 1);

    // Port 1 burst of 4 while port 0 keeps requesting
    bus.req0_addr_i = 14'h0030;
    bus.req1_rd_i = 1'b1; bus.req1_addr_i = 14'h0020; bus.req1_len_i = 2'd3;
    step("b1_k0", 0, 1, 14'h0020, 1, 1, 0);
    bus.req1_rd_i = 1'b0; bus.req1_len_i = 2'd0;
    step("b1_k1", 0, 0, 14'h0021, 1, 1, 0);
    step("b1_k2", 0, 0, 14'h0022, 1, 1, 0);
    step("b1_k3", 0, 0, 14'h0023, 1, 1, 1);
    step("b1_next0", 1, 0, 14'h0030, 1, 0, 1);
    bus.req0_rd_i = 1'b0;

    // Port 0 burst across the top of the address space
    bus.req0_rd_i = 1'b1; bus.req0_addr_i = 14'h3FFE; bus.req0_len_i = 2'd3;
    step("wrap_k0", 1, 0, 14'h3FFE, 1, 0, 0);
    bus.req0_rd_i = 1'b0; bus.req0_len_i = 2'd0;
    step("wrap_k1", 0, 0, 14'h3FFF, 1, 0, 0);
    step("wrap_k2", 0, 0, 14'h0000, 1, 0, 0);
    step("wrap_k3", 0, 0, 14'h0001, 1, 0, 1);

    // Reset during a burst: only beat 0 returns, the rest are abandoned
    bus.req0_rd_i = 1'b1; bus.req0_addr_i = 14'h0080; bus.req0_len_i = 2'd3;
    step("abort_k0", 1, 0, 14'h0080, 1, 0, 0);
    bus.req0_rd_i = 1'b0; bus.req0_len_i = 2'd0;
    @(negedge clk_i);
    #1 rst_i = 1'b1;
    #1;
    check("abort_valid0", {63'd0, bus.req0_valid_o}, 64'd0);
    check("abort_last0", {63'd0, bus.req0_last_o}, 64'd0);
    check("abort_valid1", {63'd0, bus.req1_valid_o}, 64'd0);
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;

    // Tie after reset goes to port 0
    bus.req0_rd_i = 1'b1; bus.req0_addr_i = 14'h0111;
    bus.req1_rd_i = 1'b1; bus.req1_addr_i = 14'h0222;
    step("post_rst_tie", 1, 0, 14'h0111, 1, 0, 1);
    bus.req0_rd_i = 1'b0;
    step("post_rst_p1", 0, 1, 14'h0222, 1, 1, 1);
    bus.req1_rd_i = 1'b0;

    // Idle: nothing issued, ROM address follows port 0's address
    for (int i = 0; i < 10; i++) begin
      bus.req0_addr_i = 14'h1000 + 14'(i);
      step("idle", 0, 0, 14'h1000 + 14'(i), 0, 0, 0);
    end

    repeat (2) @(negedge clk_i);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
